// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state codes, the
// per-stage stall/flush bus type and the stage index constants used to
// address bits of that bus.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CtrlRun     = 2'd0,
    CtrlDrain   = 2'd1,
    CtrlTrapJmp = 2'd2,
    CtrlHalt    = 2'd3
  } ctrl_state_e;

  localparam int unsigned StallBusW = 5;
  typedef logic [StallBusW-1:0] stall_bus_t;

  // Bit positions within stall/flush vectors.
  localparam int unsigned StgPc  = 0;
  localparam int unsigned StgIf  = 1;
  localparam int unsigned StgId  = 2;
  localparam int unsigned StgEx  = 3;
  localparam int unsigned StgMem = 4;

endpackage

// File: rtl/pipe_ctrl_stall_arb.sv
// stall_arb: combinational stall/flush priority for normal (RUN) operation.
// The deepest requesting stage wins: it and every younger stage are held,
// and a bubble is loaded into the output of the requesting stage so the
// older stages keep draining.
//   stallreq_if_i / stallreq_id_i / stallreq_ex_i : stage stall requests
//   stall_o : 1 = hold stage register (bit0 pc .. bit4 mem)
//   flush_o : 1 = load bubble into stage output register
module stall_arb
  import pipe_ctrl_pkg::*;
(
  input  logic                 stallreq_if_i,
  input  logic                 stallreq_id_i,
  input  logic                 stallreq_ex_i,
  output logic [StallBusW-1:0] stall_o,
  output logic [StallBusW-1:0] flush_o
);

  always_comb begin
    stall_o = '0;
    flush_o = '0;
    if (stallreq_ex_i) begin
      stall_o[StgEx:StgPc] = '1;
      flush_o[StgMem]      = 1'b1;
    end else if (stallreq_id_i) begin
      stall_o[StgId:StgPc] = '1;
      flush_o[StgEx]       = 1'b1;
    end else if (stallreq_if_i) begin
      stall_o[StgIf:StgPc] = '1;
      flush_o[StgId]       = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core.
// Merges redirect sources into the branch/jump pair driven to the pc block,
// produces per-stage stall/flush vectors, and sequences trap entry
// (flush+drain, then redirect to trap_vec_i) and debug halt/resume.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   stallreq_*_i          : stage stall requests (if/id/ex)
//   ex_branch_* / id_jump_*: redirect requests from ex and id
//   trap_req_i, trap_vec_i: trap request and vector base
//   halt_req_i            : debug halt level
//   branch_*_o, jump_*_o  : redirect pair to pc
//   stall_o, flush_o      : per-stage controls (bit0 pc .. bit4 mem)
//   state_o               : FSM state for debug/CSR
//   trap_ack_o            : pulse on the cycle the trap redirect is issued
// Only the state and drain counter are registered; all other outputs are
// combinational from state and inputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stallreq_if_i,
  input  logic                 stallreq_id_i,
  input  logic                 stallreq_ex_i,
  input  logic                 ex_branch_en_i,
  input  logic [ADDR_W-1:0]    ex_branch_addr_i,
  input  logic                 id_jump_en_i,
  input  logic [ADDR_W-1:0]    id_jump_addr_i,
  input  logic                 trap_req_i,
  input  logic [ADDR_W-1:0]    trap_vec_i,
  input  logic                 halt_req_i,
  output logic                 branch_enable_o,
  output logic [ADDR_W-1:0]    branch_addr_o,
  output logic                 jump_enable_o,
  output logic [ADDR_W-1:0]    jump_addr_o,
  output logic [StallBusW-1:0] stall_o,
  output logic [StallBusW-1:0] flush_o,
  output logic [1:0]           state_o,
  output logic                 trap_ack_o
);

  localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

  ctrl_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  stall_bus_t  arb_stall, arb_flush;
  logic        trap_entry;

  stall_arb u_stall_arb (
    .stallreq_if_i (stallreq_if_i),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_ex_i (stallreq_ex_i),
    .stall_o       (arb_stall),
    .flush_o       (arb_flush)
  );

  // Trap is accepted from RUN and HALT; it outranks both halt and redirects.
  assign trap_entry = trap_req_i && (state_q == CtrlRun || state_q == CtrlHalt);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    branch_enable_o = 1'b0;
    branch_addr_o   = '0;
    jump_enable_o   = 1'b0;
    jump_addr_o     = '0;
    stall_o         = '0;
    flush_o         = '0;
    trap_ack_o      = 1'b0;

    if (trap_entry) begin
      flush_o        = '1;
      stall_o[StgPc] = 1'b1;
      state_d        = CtrlDrain;
      cnt_d          = DrainLoad;
    end else begin
      case (state_q)
        CtrlRun: begin
          stall_o = arb_stall;
          flush_o = arb_flush;
          // A branch seen while ex is stalled is not yet final; ex re-presents it.
          if (ex_branch_en_i && !stallreq_ex_i) begin
            branch_enable_o      = 1'b1;
            branch_addr_o        = ex_branch_addr_i;
            stall_o[StgId:StgPc] = '0;
            flush_o[StgId]       = 1'b1;
            flush_o[StgIf]       = 1'b1;
          end else if (id_jump_en_i && !stallreq_id_i && !stallreq_ex_i) begin
            jump_enable_o  = 1'b1;
            jump_addr_o    = id_jump_addr_i;
            flush_o[StgIf] = 1'b1;
          end
          if (halt_req_i) state_d = CtrlHalt;
        end
        CtrlDrain: begin
          flush_o        = '1;
          stall_o[StgPc] = 1'b1;
          if (cnt_q == '0) state_d = CtrlTrapJmp;
          else             cnt_d   = cnt_q - 4'd1;
        end
        CtrlTrapJmp: begin
          jump_enable_o = 1'b1;
          jump_addr_o   = trap_vec_i;
          trap_ack_o    = 1'b1;
          state_d       = CtrlRun;
        end
        CtrlHalt: begin
          stall_o[StgPc] = 1'b1;
          flush_o[StgIf] = 1'b1;
          if (!halt_req_i) state_d = CtrlRun;
        end
        default: state_d = CtrlRun;
      endcase
    end

    // Reset forces every combinational output quiet in the reset cycle too.
    if (rst_i) begin
      branch_enable_o = 1'b0;
      branch_addr_o   = '0;
      jump_enable_o   = 1'b0;
      jump_addr_o     = '0;
      stall_o         = '0;
      flush_o         = '0;
      trap_ack_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CtrlRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  localparam int unsigned DRAIN = 2;

  typedef struct packed {
    logic        rst, sif, sid, sex, br;
    logic [31:0] br_a;
    logic        jmp;
    logic [31:0] jmp_a;
    logic        trap;
    logic [31:0] vec;
    logic        halt;
  } in_t;

  typedef struct packed {
    logic        ben;
    logic [31:0] ba;
    logic        jen;
    logic [31:0] ja;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic [1:0]  st;
    logic        ack;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stallreq_if_i = 1'b0, stallreq_id_i = 1'b0, stallreq_ex_i = 1'b0;
  logic        ex_branch_en_i = 1'b0, id_jump_en_i = 1'b0, trap_req_i = 1'b0, halt_req_i = 1'b0;
  logic [31:0] ex_branch_addr_i = '0, id_jump_addr_i = '0, trap_vec_i = '0;
  logic        branch_enable_o, jump_enable_o, trap_ack_o;
  logic [31:0] branch_addr_o, jump_addr_o;
  logic [4:0]  stall_o, flush_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: trap_left counts the remaining cycles of a trap sequence
  // (drain cycles followed by the single vector-jump cycle); halted tracks halt.
  int trap_left = 0;
  bit halted    = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
    .ex_branch_en_i(ex_branch_en_i), .ex_branch_addr_i(ex_branch_addr_i),
    .id_jump_en_i(id_jump_en_i), .id_jump_addr_i(id_jump_addr_i),
    .trap_req_i(trap_req_i), .trap_vec_i(trap_vec_i), .halt_req_i(halt_req_i),
    .branch_enable_o(branch_enable_o), .branch_addr_o(branch_addr_o),
    .jump_enable_o(jump_enable_o), .jump_addr_o(jump_addr_o),
    .stall_o(stall_o), .flush_o(flush_o), .state_o(state_o), .trap_ack_o(trap_ack_o)
  );

  function automatic logic [1:0] model_state();
    if (trap_left > 1) return 2'd1;
    if (trap_left == 1) return 2'd2;
    if (halted) return 2'd3;
    return 2'd0;
  endfunction

  function automatic out_t model_out(in_t i);
    out_t o;
    o    = '0;
    o.st = model_state();
    if (i.rst) return o;
    if (trap_left > 1) begin
      o.flush = 5'b11111; o.stall = 5'b00001;
    end else if (trap_left == 1) begin
      o.jen = 1'b1; o.ja = i.vec; o.ack = 1'b1;
    end else if (i.trap) begin
      o.flush = 5'b11111; o.stall = 5'b00001;
    end else if (halted) begin
      o.stall = 5'b00001; o.flush = 5'b00010;
    end else begin
      if (i.sex)      begin o.stall = 5'b01111; o.flush = 5'b10000; end
      else if (i.sid) begin o.stall = 5'b00111; o.flush = 5'b01000; end
      else if (i.sif) begin o.stall = 5'b00011; o.flush = 5'b00100; end
      if (i.br && !i.sex) begin
        o.ben = 1'b1; o.ba = i.br_a;
        o.stall = o.stall & 5'b11000;
        o.flush = o.flush | 5'b00110;
      end else if (i.jmp && !i.br && !i.sid && !i.sex) begin
        o.jen = 1'b1; o.ja = i.jmp_a;
        o.flush = o.flush | 5'b00010;
      end
    end
    return o;
  endfunction

  task automatic model_step(input in_t i);
    if (i.rst) begin
      trap_left = 0; halted = 1'b0;
    end else if (trap_left > 0) begin
      trap_left = trap_left - 1;
    end else if (i.trap) begin
      trap_left = DRAIN + 1; halted = 1'b0;
    end else begin
      halted = i.halt;
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.ben = branch_enable_o; o.ba = branch_addr_o;
    o.jen = jump_enable_o;   o.ja = jump_addr_o;
    o.stall = stall_o; o.flush = flush_o; o.st = state_o; o.ack = trap_ack_o;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    @(negedge clk);
    rst_i = i.rst; stallreq_if_i = i.sif; stallreq_id_i = i.sid; stallreq_ex_i = i.sex;
    ex_branch_en_i = i.br; ex_branch_addr_i = i.br_a;
    id_jump_en_i = i.jmp; id_jump_addr_i = i.jmp_a;
    trap_req_i = i.trap; trap_vec_i = i.vec; halt_req_i = i.halt;
    #1;
  endtask

  // Drive one cycle, compare against the model, then advance the model.
  task automatic run(input string nm, input in_t i);
    drive(i);
    chk(nm, 128'(dut_out()), 128'(model_out(i)));
    model_step(i);
  endtask

  function automatic in_t mk(bit rst, bit sif, bit sid, bit sex, bit br, bit jmp, bit trap, bit halt);
    in_t i;
    i.rst = rst; i.sif = sif; i.sid = sid; i.sex = sex;
    i.br = br; i.br_a = 32'h80; i.jmp = jmp; i.jmp_a = 32'h40;
    i.trap = trap; i.vec = 32'h100; i.halt = halt;
    return i;
  endfunction

  function automatic out_t mko(bit ben, bit jen, logic [4:0] stall, logic [4:0] flush);
    out_t o;
    o = '0;
    o.ben = ben; o.ba = ben ? 32'h80 : 32'h0;
    o.jen = jen; o.ja = jen ? 32'h40 : 32'h0;
    o.stall = stall; o.flush = flush;
    return o;
  endfunction

  vec_t tbl[$];

  initial begin
    in_t  ri;
    out_t z;
    z = '0;

    //                 rst sif sid sex br jmp trap halt
    tbl.push_back('{mk(0,0,0,0,0,0,0,0), mko(0,0,5'b00000,5'b00000)});
    tbl.push_back('{mk(0,1,0,0,0,0,0,0), mko(0,0,5'b00011,5'b00100)});
    tbl.push_back('{mk(0,0,1,0,0,0,0,0), mko(0,0,5'b00111,5'b01000)});
    tbl.push_back('{mk(0,1,1,1,0,0,0,0), mko(0,0,5'b01111,5'b10000)});
    tbl.push_back('{mk(0,0,0,0,1,1,0,0), mko(1,0,5'b00000,5'b00110)});
    tbl.push_back('{mk(0,0,0,1,1,1,0,0), mko(0,0,5'b01111,5'b10000)});
    tbl.push_back('{mk(0,0,0,0,0,1,0,0), mko(0,1,5'b00000,5'b00010)});
    tbl.push_back('{mk(0,0,1,0,0,1,0,0), mko(0,0,5'b00111,5'b01000)});
    tbl.push_back('{mk(0,0,1,0,1,0,0,0), mko(1,0,5'b00000,5'b01110)});
    tbl.push_back('{mk(0,1,0,0,0,1,0,0), mko(0,1,5'b00011,5'b00110)});
    tbl.push_back('{mk(0,1,0,0,1,0,0,0), mko(1,0,5'b00000,5'b00110)});

    // Reset held with every request high: everything quiet, state RUN.
    for (int k = 0; k < 3; k++) begin
      run("reset_model", mk(1,1,1,1,1,1,1,1));
      chk("reset_quiet", 128'(dut_out()), 128'(z));
    end

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      chk($sformatf("table_%0d", k), 128'(dut_out()), 128'(tbl[k].e));
      model_step(tbl[k].i);
    end

    // Single-cycle id stall then release.
    run("id_stall", mk(0,0,1,0,0,0,0,0));
    chk("id_stall_vec", {stall_o, flush_o}, {5'b00111, 5'b01000});
    run("id_release", mk(0,0,0,0,0,0,0,0));
    chk("id_release_vec", {stall_o, flush_o}, 10'h0);

    // Trap pulse; a repeated request mid-drain must not restart the count.
    run("trap_c0", mk(0,0,0,0,1,1,1,0));
    chk("trap_c0", {state_o, flush_o, branch_enable_o, jump_enable_o}, {2'd0, 5'b11111, 2'b00});
    run("trap_c1", mk(0,1,1,1,1,1,0,0));
    chk("trap_c1", {state_o, flush_o, stall_o}, {2'd1, 5'b11111, 5'b00001});
    run("trap_c2", mk(0,0,0,0,0,0,1,0));
    chk("trap_c2", {state_o, flush_o}, {2'd1, 5'b11111});
    run("trap_c3", mk(0,0,0,0,0,0,0,0));
    chk("trap_c3", {state_o, jump_enable_o, jump_addr_o, trap_ack_o, flush_o},
        {2'd2, 1'b1, 32'h100, 1'b1, 5'b00000});
    run("trap_c4", mk(0,0,0,0,0,0,0,0));
    chk("trap_c4", {state_o, trap_ack_o}, {2'd0, 1'b0});

    // Halt for 4 cycles, release, then halt again and trap during halt.
    for (int k = 0; k < 4; k++) begin
      run("halt_model", mk(0,0,0,0,0,0,0,1));
      if (k > 0) chk("halt_hold", {state_o, stall_o, flush_o}, {2'd3, 5'b00001, 5'b00010});
    end
    run("halt_rel0", mk(0,0,0,0,0,0,0,0));
    run("halt_rel1", mk(0,0,0,0,0,0,0,0));
    chk("halt_resume", 128'(state_o), 128'(0));
    run("halt_again", mk(0,0,0,0,0,0,0,1));
    run("halt_trap", mk(0,0,0,0,0,0,1,1));
    chk("halt_trap_state", 128'(state_o), 128'(3));
    run("drain1", mk(0,0,0,0,0,0,0,1));
    chk("halt_to_drain", 128'(state_o), 128'(1));
    // Reset in the second drain cycle: back to RUN, no ack ever.
    run("drain2_rst", mk(1,0,0,0,0,0,0,0));
    chk("rst_in_drain", {state_o, trap_ack_o, flush_o, stall_o}, {2'd1, 1'b0, 10'h0});
    for (int k = 0; k < 4; k++) begin
      run("post_rst", mk(0,0,0,0,0,0,0,0));
      chk("post_rst_no_ack", {state_o, trap_ack_o}, {2'd0, 1'b0});
    end

    // Randomized traffic against the model.
    ri = mk(0,0,0,0,0,0,0,0);
    for (int k = 0; k < 3000; k++) begin
      ri.rst   = ($urandom_range(0, 99) == 0);
      ri.sif   = ($urandom_range(0, 3) == 0);
      ri.sid   = ($urandom_range(0, 3) == 0);
      ri.sex   = ($urandom_range(0, 3) == 0);
      ri.br    = ($urandom_range(0, 2) == 0);
      ri.jmp   = ($urandom_range(0, 2) == 0);
      ri.trap  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) ri.halt = ~ri.halt;
      ri.br_a  = $urandom;
      ri.jmp_a = $urandom;
      ri.vec   = $urandom;
      run("random", ri);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
